cos_match_engine: RTL and testbench

//   Streaming cosine-similarity match engine for face-embedding verification, successor to the float32 IP block.

---
 rtl/cos_match_pkg.sv | 35 +++
 rtl/cos_lane_mac.sv | 43 ++++
 rtl/cos_match_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_cos_match_engine.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cos_match_pkg.sv
// ============================================================================
// Module      : cos_match_pkg
// Description : Shared types and sizing helpers for the cosine match engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cos_match_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC   = 3'd1,
        S_DRAIN = 3'd2,
        S_SQ    = 3'd3,
        S_CMP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Wide enough that a full vector of worst-case products cannot overflow.
    function automatic int acc_width(input int d_len, input int ele_num);
        return 2 * d_len + $clog2(ele_num) + 1;
    endfunction

    function automatic int beat_count(input int ele_num, input int lanes);
        return ele_num / lanes;
    endfunction

    // Threshold is unsigned Q1.TF: one integer bit plus TF fraction bits.
    function automatic int thr_width(input int tf);
        return tf + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cos_lane_mac.sv
// ============================================================================
// Module      : cos_lane_mac
// Description : One lane of the first pipeline stage: registered a*b, a*a, b*b.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cos_lane_mac #(
    parameter int D_LEN = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_en,
    input  logic signed [D_LEN-1:0]     i_a,
    input  logic signed [D_LEN-1:0]     i_b,
    output logic signed [2*D_LEN-1:0]   o_ab,
    output logic signed [2*D_LEN-1:0]   o_aa,
    output logic signed [2*D_LEN-1:0]   o_bb
);

    logic signed [2*D_LEN-1:0] r_ab;
    logic signed [2*D_LEN-1:0] r_aa;
    logic signed [2*D_LEN-1:0] r_bb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ab <= '0;
            r_aa <= '0;
            r_bb <= '0;
        end else if (i_en) begin
            r_ab <= i_a * i_b;
            r_aa <= i_a * i_a;
            r_bb <= i_b * i_b;
        end
    end

    assign o_ab = r_ab;
    assign o_aa = r_aa;
    assign o_bb = r_bb;

endmodule

`default_nettype wire

// File: rtl/cos_match_engine.sv
// ============================================================================
// Module      : cos_match_engine
// Description : Streaming fixed-point cosine-similarity threshold decision.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cos_match_engine
    import cos_match_pkg::*;
#(
    parameter int D_LEN   = 16,
    parameter int FRAC    = 12,
    parameter int ELE_NUM = 128,
    parameter int LANES   = 4,
    parameter int TF      = 15,
    localparam int c_ACC_W = acc_width(D_LEN, ELE_NUM)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic [thr_width(TF)-1:0]    i_thr,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [LANES*D_LEN-1:0]      i_in_a,
    input  logic [LANES*D_LEN-1:0]      i_in_b,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [c_ACC_W-1:0]          o_dot,
    output logic [c_ACC_W-1:0]          o_norm_a,
    output logic [c_ACC_W-1:0]          o_norm_b,
    output logic                        o_match,
    output logic                        o_zero_vec
);

    localparam int c_BEATS = beat_count(ELE_NUM, LANES);
    localparam int c_CNT_W = $clog2(c_BEATS + 1);
    localparam int c_PQ_W  = 2 * c_ACC_W;
    localparam int c_CMP_W = c_PQ_W + 2 * thr_width(TF);
    localparam int c_THR_W = thr_width(TF);

    if (FRAC >= D_LEN || (ELE_NUM % LANES) != 0) begin : g_param_check
        $error("cos_match_engine: illegal parameter combination");
    end

    state_t                    r_state;
    state_t                    w_next;
    logic [c_CNT_W-1:0]        r_beat_cnt;
    logic                      r_drain_cnt;
    logic                      r_s1_vld;
    logic [c_ACC_W-1:0]        r_acc_dot;
    logic [c_ACC_W-1:0]        r_acc_na;
    logic [c_ACC_W-1:0]        r_acc_nb;
    logic [c_THR_W-1:0]        r_thr;
    logic [c_PQ_W-1:0]         r_p;
    logic [c_PQ_W-1:0]         r_q;
    logic [c_ACC_W-1:0]        r_dot;
    logic [c_ACC_W-1:0]        r_na;
    logic [c_ACC_W-1:0]        r_nb;
    logic                      r_match;
    logic                      r_zero;

    logic                      w_start_ok;
    logic                      w_fire;
    logic                      w_last;
    logic [c_ACC_W-1:0]        w_sum_ab;
    logic [c_ACC_W-1:0]        w_sum_aa;
    logic [c_ACC_W-1:0]        w_sum_bb;
    logic [c_PQ_W-1:0]         w_dot_ext;
    logic [c_PQ_W-1:0]         w_p;
    logic [c_PQ_W-1:0]         w_q;
    logic [c_CMP_W-1:0]        w_lhs;
    logic [c_CMP_W-1:0]        w_rhs;
    logic                      w_zero;
    logic                      w_dot_neg;
    logic                      w_match;

    logic signed [2*D_LEN-1:0] w_ab [LANES];
    logic signed [2*D_LEN-1:0] w_aa [LANES];
    logic signed [2*D_LEN-1:0] w_bb [LANES];

    assign w_start_ok = i_start && !i_abort && (r_state == S_IDLE || r_state == S_DONE);
    assign w_fire     = i_in_valid && o_in_ready;
    assign w_last     = w_fire && (r_beat_cnt == c_CNT_W'(c_BEATS - 1));

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        cos_lane_mac #(
            .D_LEN (D_LEN)
        ) u_mac (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (w_fire),
            .i_a   (i_in_a[g*D_LEN +: D_LEN]),
            .i_b   (i_in_b[g*D_LEN +: D_LEN]),
            .o_ab  (w_ab[g]),
            .o_aa  (w_aa[g]),
            .o_bb  (w_bb[g])
        );
    end

    // Lane tree: dot terms are sign-extended, squares are never negative.
    always_comb begin
        w_sum_ab = '0;
        w_sum_aa = '0;
        w_sum_bb = '0;
        for (int l = 0; l < LANES; l++) begin
            w_sum_ab = w_sum_ab + {{(c_ACC_W-2*D_LEN){w_ab[l][2*D_LEN-1]}}, w_ab[l]};
            w_sum_aa = w_sum_aa + {{(c_ACC_W-2*D_LEN){1'b0}}, w_aa[l]};
            w_sum_bb = w_sum_bb + {{(c_ACC_W-2*D_LEN){1'b0}}, w_bb[l]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start_ok) w_next = S_ACC;
                S_ACC:   if (w_last) w_next = S_DRAIN;
                S_DRAIN: if (r_drain_cnt) w_next = S_SQ;
                S_SQ:    w_next = S_CMP;
                S_CMP:   w_next = S_DONE;
                S_DONE:  w_next = w_start_ok ? S_ACC : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_in_ready = (r_state == S_ACC) && !i_abort;
        o_busy     = (r_state == S_ACC) || (r_state == S_DRAIN) ||
                     (r_state == S_SQ)  || (r_state == S_CMP);
        o_done     = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt  <= '0;
            r_drain_cnt <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_acc_dot   <= '0;
            r_acc_na    <= '0;
            r_acc_nb    <= '0;
            r_thr       <= '0;
        end else begin
            r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
            if (w_start_ok) begin
                r_beat_cnt <= '0;
                r_s1_vld   <= 1'b0;
                r_acc_dot  <= '0;
                r_acc_na   <= '0;
                r_acc_nb   <= '0;
                r_thr      <= i_thr;
            end else begin
                r_s1_vld <= w_fire;
                if (w_fire) begin
                    r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
                end
                if (r_s1_vld) begin
                    r_acc_dot <= r_acc_dot + w_sum_ab;
                    r_acc_na  <= r_acc_na + w_sum_aa;
                    r_acc_nb  <= r_acc_nb + w_sum_bb;
                end
            end
        end
    end

    // Squaring both sides of cos >= thr avoids any divider or square root.
    assign w_dot_ext = {{c_ACC_W{r_acc_dot[c_ACC_W-1]}}, r_acc_dot};
    assign w_p       = w_dot_ext * w_dot_ext;
    assign w_q       = c_PQ_W'(r_acc_na) * c_PQ_W'(r_acc_nb);
    assign w_lhs     = c_CMP_W'(r_p) << (2 * TF);
    assign w_rhs     = c_CMP_W'(r_thr) * c_CMP_W'(r_thr) * c_CMP_W'(r_q);
    assign w_zero    = (r_acc_na == '0) || (r_acc_nb == '0);
    assign w_dot_neg = r_acc_dot[c_ACC_W-1];

    always_comb begin
        w_match = 1'b0;
        if (!w_zero) begin
            if (r_thr == '0) begin
                w_match = !w_dot_neg;
            end else begin
                w_match = !w_dot_neg && (r_acc_dot != '0) && (w_lhs >= w_rhs);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p     <= '0;
            r_q     <= '0;
            r_dot   <= '0;
            r_na    <= '0;
            r_nb    <= '0;
            r_match <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            if (r_state == S_SQ) begin
                r_p <= w_p;
                r_q <= w_q;
            end
            if (r_state == S_CMP && !i_abort) begin
                r_dot   <= r_acc_dot;
                r_na    <= r_acc_na;
                r_nb    <= r_acc_nb;
                r_match <= w_match;
                r_zero  <= w_zero;
            end
        end
    end

    assign o_dot      = r_dot;
    assign o_norm_a   = r_na;
    assign o_norm_b   = r_nb;
    assign o_match    = r_match;
    assign o_zero_vec = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_cos_match_engine.sv
// ============================================================================
// Module      : tb_cos_match_engine
// Description : Self-checking bench for cos_match_engine with expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cos_match_engine;

    localparam int D_LEN   = 16;
    localparam int FRAC    = 12;
    localparam int ELE_NUM = 128;
    localparam int LANES   = 4;
    localparam int TF      = 15;
    localparam int ACC_W   = 2 * D_LEN + $clog2(ELE_NUM) + 1;
    localparam int BEATS   = ELE_NUM / LANES;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     i_start;
    logic                     i_abort;
    logic [TF:0]              i_thr;
    logic                     i_in_valid;
    logic                     o_in_ready;
    logic [LANES*D_LEN-1:0]   i_in_a;
    logic [LANES*D_LEN-1:0]   i_in_b;
    logic                     o_busy;
    logic                     o_done;
    logic [ACC_W-1:0]         o_dot;
    logic [ACC_W-1:0]         o_norm_a;
    logic [ACC_W-1:0]         o_norm_b;
    logic                     o_match;
    logic                     o_zero_vec;

    cos_match_engine #(
        .D_LEN   (D_LEN),
        .FRAC    (FRAC),
        .ELE_NUM (ELE_NUM),
        .LANES   (LANES),
        .TF      (TF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_thr      (i_thr),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_in_a     (i_in_a),
        .i_in_b     (i_in_b),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_dot      (o_dot),
        .o_norm_a   (o_norm_a),
        .o_norm_b   (o_norm_b),
        .o_match    (o_match),
        .o_zero_vec (o_zero_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint dot;
        longint na;
        longint nb;
        bit     m;
        bit     z;
        bit     lat;
    } exp_t;

    typedef struct {
        int          pat;
        logic [15:0] thr;
        bit          gaps;
        bit          has_const;
        longint      dot;
        longint      na;
        longint      nb;
        bit          m;
        bit          z;
    } vec_t;

    exp_t                    sb[$];
    vec_t                    tbl[9];
    logic signed [D_LEN-1:0] va [ELE_NUM];
    logic signed [D_LEN-1:0] vb [ELE_NUM];
    int                      checks = 0;
    int                      errors = 0;
    int                      cyc = 0;
    int                      last_beat_cyc = 0;
    longint                  last_dot = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dot", longint'($signed(o_dot)), e.dot);
                chk("norm_a", longint'(o_norm_a), e.na);
                chk("norm_b", longint'(o_norm_b), e.nb);
                chk("match", longint'(o_match), longint'(e.m));
                chk("zero_vec", longint'(o_zero_vec), longint'(e.z));
                if (e.lat) chk("latency", longint'(cyc - last_beat_cyc), 64'sd5);
                last_dot = e.dot;
            end
        end
    end

    task automatic fill(input int pat);
        for (int i = 0; i < ELE_NUM; i++) begin
            int a;
            int b;
            a = 0;
            b = 0;
            case (pat)
                0: begin a = 16'sh1000; b = 16'sh1000; end
                1: begin a = (i < 64) ? 4096 : 0; b = (i >= 64) ? 4096 : 0; end
                2: begin a = 4096; b = -4096; end
                3: begin a = 0; b = 4096; end
                5: begin a = int'($urandom_range(0, 32000)) - 16000; b = a + int'($urandom_range(0, 512)) - 256; end
                8: begin a = int'($urandom_range(0, 32000)) - 16000; b = -a + int'($urandom_range(0, 512)) - 256; end
                default: begin a = int'($urandom_range(0, 65535)) - 32768; b = int'($urandom_range(0, 65535)) - 32768; end
            endcase
            va[i] = D_LEN'(a);
            vb[i] = D_LEN'(b);
        end
    endtask

    function automatic exp_t model(input logic [15:0] thr);
        exp_t   e;
        longint d;
        longint na;
        longint nb;
        real    c;
        d  = 0;
        na = 0;
        nb = 0;
        for (int i = 0; i < ELE_NUM; i++) begin
            d  += longint'(va[i]) * longint'(vb[i]);
            na += longint'(va[i]) * longint'(va[i]);
            nb += longint'(vb[i]) * longint'(vb[i]);
        end
        e.dot = d;
        e.na  = na;
        e.nb  = nb;
        e.z   = (na == 0) || (nb == 0);
        e.lat = 1'b0;
        if (e.z) begin
            e.m = 1'b0;
        end else if (thr == 16'h0) begin
            e.m = (d >= 0);
        end else begin
            c   = real'(d) / $sqrt(real'(na) * real'(nb));
            e.m = (d > 0) && (c >= real'(thr) / 32768.0);
        end
        return e;
    endfunction

    task automatic do_start(input logic [15:0] thr);
        @(negedge clk);
        i_start = 1'b1;
        i_thr   = thr;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic send(input int first, input int last, input bit gaps);
        int beat;
        int guard;
        bit fired;
        beat  = first;
        guard = 0;
        while (beat < last && guard < 4000) begin
            i_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int l = 0; l < LANES; l++) begin
                i_in_a[l*D_LEN +: D_LEN] = va[beat*LANES + l];
                i_in_b[l*D_LEN +: D_LEN] = vb[beat*LANES + l];
            end
            @(negedge clk);
            fired = i_in_valid && o_in_ready;
            @(posedge clk);
            #1;
            if (fired) begin
                beat++;
                last_beat_cyc = cyc - 1;
            end
            guard++;
        end
        i_in_valid = 1'b0;
        if (beat < last) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got %0d beats expected %0d", beat, last);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        exp_t e;
        tbl[0] = '{0, 16'h4000, 1'b0, 1'b1, 64'h80000000, 64'h80000000, 64'h80000000, 1'b1, 1'b0};
        tbl[1] = '{1, 16'h4000, 1'b0, 1'b1, 64'h0, 64'h40000000, 64'h40000000, 1'b0, 1'b0};
        tbl[2] = '{2, 16'h0000, 1'b0, 1'b1, -64'sd2147483648, 64'h80000000, 64'h80000000, 1'b0, 1'b0};
        tbl[3] = '{3, 16'h4000, 1'b0, 1'b1, 64'h0, 64'h0, 64'h80000000, 1'b0, 1'b1};
        tbl[4] = '{4, 16'h4000, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        tbl[5] = '{5, 16'h4000, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        tbl[6] = '{6, 16'h0000, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        tbl[7] = '{0, 16'h8000, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        tbl[8] = '{8, 16'h0000, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0};

        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_abort    = 1'b0;
        i_thr      = '0;
        i_in_valid = 1'b0;
        i_in_a     = '0;
        i_in_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(o_in_ready), 0);
        chk("rst_busy", longint'(o_busy), 0);
        chk("rst_done", longint'(o_done), 0);
        chk("rst_dot", longint'(o_dot), 0);
        chk("rst_match", longint'(o_match), 0);
        chk("rst_zero", longint'(o_zero_vec), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int r = 0; r < 9; r++) begin
            fill(tbl[r].pat);
            if (tbl[r].has_const) begin
                e = '{tbl[r].dot, tbl[r].na, tbl[r].nb, tbl[r].m, tbl[r].z, 1'b0};
            end else begin
                e = model(tbl[r].thr);
            end
            e.lat = !tbl[r].gaps;
            do_start(tbl[r].thr);
            sb.push_back(e);
            send(0, BEATS, tbl[r].gaps);
            wait_drain();
        end

        // A start pulse mid-vector must not restart the comparison.
        fill(0);
        do_start(16'h4000);
        chk("busy_after_start", longint'(o_busy), 1);
        e = '{64'h80000000, 64'h80000000, 64'h80000000, 1'b1, 1'b0, 1'b1};
        sb.push_back(e);
        send(0, 10, 1'b0);
        do_start(16'h0000);
        send(10, BEATS, 1'b0);
        wait_drain();

        // Abort mid-accumulation: no done, outputs hold, then a clean rerun.
        fill(4);
        do_start(16'h4000);
        send(0, 16, 1'b1);
        @(negedge clk);
        i_abort = 1'b1;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        i_start = 1'b0;
        chk("abort_busy", longint'(o_busy), 0);
        chk("abort_in_ready", longint'(o_in_ready), 0);
        chk("abort_dot_hold", longint'($signed(o_dot)), last_dot);
        repeat (12) @(posedge clk);
        e = model(16'h4000);
        do_start(16'h4000);
        sb.push_back(e);
        send(0, BEATS, 1'b1);
        wait_drain();

        // Asynchronous reset in the middle of a vector.
        fill(5);
        do_start(16'h4000);
        send(0, 8, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", longint'(o_busy), 0);
        chk("mid_rst_in_ready", longint'(o_in_ready), 0);
        chk("mid_rst_dot", longint'(o_dot), 0);
        chk("mid_rst_norm_a", longint'(o_norm_a), 0);
        chk("mid_rst_norm_b", longint'(o_norm_b), 0);
        chk("mid_rst_match", longint'(o_match), 0);
        chk("mid_rst_zero", longint'(o_zero_vec), 0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
